// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//
// Purpose: shared definitions for the register-file write-port arbiter and
//          its requester-B FIFO: field widths, the write-request record and
//          the per-cycle grant encoding.
//
// Contents:
//   REGNUM_W  - width of a register number (32 architectural registers)
//   DATA_W    - width of a register value
//   wr_req_t  - one pending register write {regnum, data}
//   grant_t   - which requester (if any) owns the write port this cycle
//   reg_commits() - true when a write to the given register is observable
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int REGNUM_W = 5;
    localparam int DATA_W   = 32;

    // A single register write as carried through the B-side FIFO.
    typedef struct packed {
        logic [REGNUM_W-1:0] regnum;
        logic [DATA_W-1:0]   data;
    } wr_req_t;

    // Outcome of one arbitration cycle.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } grant_t;

    // Register 0 is hard-wired to zero, so a write to it is consumed but
    // never reaches the register file.
    function automatic logic reg_commits(input logic [REGNUM_W-1:0] regnum);
        return (regnum != '0);
    endfunction

endpackage

// File: rtl/wr_req_fifo.sv
// ---------------------------------------------------------------------------
// wr_req_fifo
//
// Purpose: small circular FIFO holding register writes from requester B
//          until the arbiter grants them. The head entry is presented
//          combinationally so the arbiter can forward it in the grant cycle.
//
// Parameters:
//   DEPTH        - number of entries
//
// Ports:
//   clk          - rising-edge clock
//   reset        - synchronous active-high reset; discards all entries
//   push         - write push_regnum/push_data at the tail
//   push_regnum  - register number of the entry being pushed
//   push_data    - value of the entry being pushed
//   pop          - remove the head entry
//   full         - all DEPTH entries occupied
//   empty        - no entries occupied
//   head_regnum  - register number of the oldest entry
//   head_data    - value of the oldest entry
//
// A push while full is accepted only if a pop happens in the same cycle,
// which keeps occupancy unchanged and preserves ordering.
// ---------------------------------------------------------------------------
module wr_req_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [REGNUM_W-1:0] push_regnum,
    input  logic [DATA_W-1:0]   push_data,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output logic [REGNUM_W-1:0] head_regnum,
    output logic [DATA_W-1:0]   head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wr_req_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so depths that are not a power of two work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign do_pop      = pop && !empty;
    // A full FIFO can still take a new entry when the head leaves this cycle.
    assign do_push     = push && (!full || do_pop);
    assign head_regnum = mem[rd_ptr].regnum;
    assign head_data   = mem[rd_ptr].data;

    // Storage needs no reset: the occupancy count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr].regnum <= push_regnum;
            mem[wr_ptr].data   <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Purpose: shares the single register-file write port between requester A
//          (ALU writeback, never buffered) and requester B (load /
//          multi-cycle unit, queued in a small FIFO). A normally wins; the
//          FIFO head is written whenever A is idle. The granted write is
//          registered and appears on wr_* exactly one cycle after the grant.
//
// Build option:
//   WRARB_STARVE_GUARD_EN - when defined, a starvation counter forces a
//       grant to the FIFO head after it has lost STARVE_LIMIT consecutive
//       cycles to A; in that cycle a_ready drops. When undefined, A has
//       strict priority and a_ready is 1 whenever reset is low.
//
// Parameters:
//   STARVE_LIMIT - consecutive lost cycles before the FIFO head is forced
//   B_DEPTH      - requester-B FIFO entries (only 2 is supported)
//
// Ports:
//   clk          - rising-edge clock
//   reset        - synchronous active-high reset
//   a_valid      - A has a write this cycle
//   a_regnum     - A destination register
//   a_data       - A write value
//   a_ready      - A write taken this cycle when a_valid & a_ready
//   b_valid      - B has a write this cycle
//   b_regnum     - B destination register
//   b_data       - B write value
//   b_ready      - FIFO can take the B write this cycle
//   wr_regnum    - register-file write address (held when idle)
//   wr_data      - register-file write data (held when idle)
//   wr_enable    - register-file write strobe
//   b_pending    - FIFO holds at least one write
// ---------------------------------------------------------------------------
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int B_DEPTH      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_valid,
    input  logic [REGNUM_W-1:0] a_regnum,
    input  logic [DATA_W-1:0]   a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [REGNUM_W-1:0] b_regnum,
    input  logic [DATA_W-1:0]   b_data,
    output logic                b_ready,
    output logic [REGNUM_W-1:0] wr_regnum,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_enable,
    output logic                b_pending
);

    // Reject unsupported configurations at elaboration time.
    if (B_DEPTH != 2 || STARVE_LIMIT < 0) begin : g_bad_params
        $error("regfile_wr_arbiter: B_DEPTH must be 2 and STARVE_LIMIT must be non-negative");
    end

    logic                fifo_full;
    logic                fifo_empty;
    logic [REGNUM_W-1:0] head_regnum;
    logic [DATA_W-1:0]   head_data;
    logic                fifo_push;
    logic                fifo_pop;
    logic                forced_b;
    grant_t              grant;
    wr_req_t             granted_req;

    wr_req_fifo #(
        .DEPTH (B_DEPTH)
    ) u_b_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (fifo_push),
        .push_regnum (b_regnum),
        .push_data   (b_data),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_regnum (head_regnum),
        .head_data   (head_data)
    );

`ifdef WRARB_STARVE_GUARD_EN
    localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;

    assign forced_b = !fifo_empty && (starve_cnt == STARVE_MAX);

    // Counts consecutive cycles the FIFO head lost to A. It restarts as soon
    // as the head is written or the FIFO drains, and sticks at the limit so
    // the forced grant stays asserted until the head actually goes out.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (fifo_empty || grant == GRANT_B) begin
            starve_cnt <= '0;
        end else if (grant == GRANT_A && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end
`else
    // Strict A priority: the FIFO head only goes out on cycles A is idle.
    assign forced_b = 1'b0;
`endif

    // One grant per cycle at most. A wins unless the starvation guard has
    // fired; otherwise the FIFO head goes if there is one. Nothing is
    // granted while reset is high.
    always_comb begin
        grant = GRANT_NONE;
        if (!reset) begin
            if (a_valid && !forced_b) begin
                grant = GRANT_A;
            end else if (!fifo_empty) begin
                grant = GRANT_B;
            end
        end
    end

    // A is never buffered, so it is ready every cycle except a forced-B one.
    // B may enter a full FIFO only when the head leaves in the same cycle.
    // A B write arriving at an empty FIFO is only enqueued here; it becomes
    // the head (and can be granted) in the following cycle.
    assign a_ready   = !reset && !forced_b;
    assign b_ready   = !reset && (!fifo_full || grant == GRANT_B);
    assign fifo_push = b_valid && b_ready;
    assign fifo_pop  = (grant == GRANT_B);
    assign b_pending = !fifo_empty;

    // Select the payload of whichever requester owns the port this cycle.
    always_comb begin
        granted_req.regnum = head_regnum;
        granted_req.data   = head_data;
        if (grant == GRANT_A) begin
            granted_req.regnum = a_regnum;
            granted_req.data   = a_data;
        end
    end

    // Register-file write port. Address and data are captured on every
    // grant and held otherwise; the strobe is suppressed for register 0 so
    // such writes are consumed without effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_enable <= 1'b0;
            wr_regnum <= '0;
            wr_data   <= '0;
        end else begin
            wr_enable <= 1'b0;
            if (grant != GRANT_NONE) begin
                wr_regnum <= granted_req.regnum;
                wr_data   <= granted_req.data;
                wr_enable <= reg_commits(granted_req.regnum);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Purpose: self-checking bench for regfile_wr_arbiter. Accepted A and B
//          writes are pushed into expectation queues at the handshake; each
//          register-file write the DUT produces is popped and compared.
//          Directed checks cover reset, latency, starvation and back-pressure.
//          Expectations follow WRARB_STARVE_GUARD_EN when it is defined.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

`ifdef WRARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic                a_valid;
    logic [REGNUM_W-1:0] a_regnum;
    logic [DATA_W-1:0]   a_data;
    logic                a_ready;
    logic                b_valid;
    logic [REGNUM_W-1:0] b_regnum;
    logic [DATA_W-1:0]   b_data;
    logic                b_ready;
    logic [REGNUM_W-1:0] wr_regnum;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_enable;
    logic                b_pending;

    int passCount;
    int checkCount;

    wr_req_t aQueue[$];
    wr_req_t bQueue[$];

    regfile_wr_arbiter #(
        .STARVE_LIMIT (3),
        .B_DEPTH      (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_regnum  (a_regnum),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_regnum  (b_regnum),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .wr_regnum (wr_regnum),
        .wr_data   (wr_data),
        .wr_enable (wr_enable),
        .b_pending (b_pending)
    );

    // Free-running clock, rising edge active.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // Drives both requesters (called just after a falling edge) and lets
    // the combinational handshake outputs settle.
    task automatic applyStimulus(input logic av, input logic [REGNUM_W-1:0] ar,
                                 input logic [DATA_W-1:0] ad, input logic bv,
                                 input logic [REGNUM_W-1:0] br,
                                 input logic [DATA_W-1:0] bd);
        a_valid  = av;
        a_regnum = ar;
        a_data   = ad;
        b_valid  = bv;
        b_regnum = br;
        b_data   = bd;
        #1;
    endtask

    // Records this cycle's handshakes as expectations, advances one clock,
    // then matches the registered write port against the queues. An A write
    // accepted last cycle must be the one on the port now; any other write
    // must be the oldest accepted B write. Reset discards queued B writes.
    task automatic stepCycle();
        wr_req_t exp;
        if (reset) begin
            bQueue.delete();
        end
        if (a_valid && a_ready) begin
            exp.regnum = a_regnum;
            exp.data   = a_data;
            aQueue.push_back(exp);
        end
        if (b_valid && b_ready) begin
            exp.regnum = b_regnum;
            exp.data   = b_data;
            bQueue.push_back(exp);
        end
        @(posedge clk);
        @(negedge clk);
        if (aQueue.size() > 0) begin
            exp = aQueue.pop_front();
            checkOutput("a_wr_enable", 32'(wr_enable), 32'(exp.regnum != '0));
            if (exp.regnum != '0) begin
                checkOutput("a_wr_regnum", 32'(wr_regnum), 32'(exp.regnum));
                checkOutput("a_wr_data", wr_data, exp.data);
            end
        end else if (wr_enable) begin
            checkOutput("b_write_expected", 32'(bQueue.size() > 0), 32'd1);
            if (bQueue.size() > 0) begin
                exp = bQueue.pop_front();
                checkOutput("b_wr_regnum", 32'(wr_regnum), 32'(exp.regnum));
                checkOutput("b_wr_data", wr_data, exp.data);
            end
        end
    endtask

    // Directed scenario sequence.
    initial begin
        int n;
        passCount  = 0;
        checkCount = 0;
        reset      = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

        // Reset: handshakes low while asserted, outputs cleared afterwards.
        @(negedge clk);
        applyStimulus(1'b1, 5'd4, 32'h1234_5678, 1'b1, 5'd5, 32'h0000_0005);
        checkOutput("rst_a_ready", 32'(a_ready), 32'd0);
        checkOutput("rst_b_ready", 32'(b_ready), 32'd0);
        stepCycle();
        checkOutput("rst_wr_enable", 32'(wr_enable), 32'd0);
        checkOutput("rst_wr_regnum", 32'(wr_regnum), 32'd0);
        checkOutput("rst_wr_data", wr_data, 32'd0);
        checkOutput("rst_b_pending", 32'(b_pending), 32'd0);

        // First cycle out of reset: A write to r1 lands one cycle later.
        reset = 1'b0;
        applyStimulus(1'b1, 5'd1, 32'hffff_ffff, 1'b0, '0, '0);
        checkOutput("post_rst_a_ready", 32'(a_ready), 32'd1);
        checkOutput("post_rst_b_ready", 32'(b_ready), 32'd1);
        stepCycle();
        checkOutput("a1_wr_enable", 32'(wr_enable), 32'd1);

        // Idle cycle: strobe drops, address and data hold.
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        stepCycle();
        checkOutput("idle_wr_enable", 32'(wr_enable), 32'd0);
        checkOutput("idle_wr_regnum", 32'(wr_regnum), 32'd1);
        checkOutput("idle_wr_data", wr_data, 32'hffff_ffff);

        // Single B write with A idle: pending next cycle, written the cycle after.
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd2, 32'h3124_0498);
        checkOutput("b1_b_ready", 32'(b_ready), 32'd1);
        stepCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("b1_pending", 32'(b_pending), 32'd1);
        checkOutput("b1_no_bypass", 32'(wr_enable), 32'd0);
        stepCycle();
        checkOutput("b1_wr_enable", 32'(wr_enable), 32'd1);
        checkOutput("b1_drained", 32'(b_pending), 32'd0);

        // Write to r0 is accepted but never strobes the register file.
        applyStimulus(1'b1, 5'd0, 32'h8765_4321, 1'b0, '0, '0);
        checkOutput("r0_a_ready", 32'(a_ready), 32'd1);
        stepCycle();
        checkOutput("r0_wr_enable", 32'(wr_enable), 32'd0);

        // A busy every cycle with one B entry queued alongside the first A.
        applyStimulus(1'b1, 5'd10, 32'ha000_0000, 1'b1, 5'd9, 32'h0b0b_0009);
        checkOutput("starve_b_ready", 32'(b_ready), 32'd1);
        stepCycle();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 5'(10 + k), 32'ha000_0000 + 32'(k), 1'b0, '0, '0);
            checkOutput("starve_a_ready", 32'(a_ready), (GUARD && k == 4) ? 32'd0 : 32'd1);
            stepCycle();
        end
        checkOutput("starve_b_pending", 32'(b_pending), GUARD ? 32'd0 : 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        n = 0;
        while (b_pending && n < 8) begin
            stepCycle();
            n++;
        end
        checkOutput("starve_drain", 32'(b_pending), 32'd0);
        checkOutput("starve_bq_empty", 32'(bQueue.size()), 32'd0);

        // Three back-to-back B writes while A is busy: the third waits.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'(20 + k), 32'hc000_0000 + 32'(k), 1'b1,
                          (k < 3) ? 5'(1 + k) : 5'd3,
                          (k < 3) ? 32'h1111_1111 * 32'(k + 1) : 32'h3333_3333);
            checkOutput("bp_b_ready", 32'(b_ready), (k < 2) ? 32'd1 : 32'd0);
            stepCycle();
        end
        // A goes idle: the head leaves while the third write enters the full FIFO.
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 32'h3333_3333);
        checkOutput("bp_pushpop_b_ready", 32'(b_ready), 32'd1);
        stepCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        n = 0;
        while (b_pending && n < 8) begin
            stepCycle();
            n++;
        end
        checkOutput("bp_drain", 32'(b_pending), 32'd0);
        checkOutput("bp_bq_empty", 32'(bQueue.size()), 32'd0);

        // Fill the FIFO under A traffic, then reset: queued writes vanish.
        applyStimulus(1'b1, 5'd25, 32'hd000_0025, 1'b1, 5'd6, 32'h0606_0606);
        stepCycle();
        applyStimulus(1'b1, 5'd26, 32'hd000_0026, 1'b1, 5'd7, 32'h0707_0707);
        stepCycle();
        reset = 1'b1;
        applyStimulus(1'b1, 5'd27, 32'hd000_0027, 1'b0, '0, '0);
        checkOutput("rst2_pending_before", 32'(b_pending), 32'd1);
        checkOutput("rst2_a_ready", 32'(a_ready), 32'd0);
        checkOutput("rst2_b_ready", 32'(b_ready), 32'd0);
        stepCycle();
        reset = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("rst2_b_pending", 32'(b_pending), 32'd0);
        checkOutput("rst2_wr_enable", 32'(wr_enable), 32'd0);
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            checkOutput("rst2_no_write", 32'(wr_enable), 32'd0);
        end

        // Normal traffic resumes immediately.
        applyStimulus(1'b1, 5'd3, 32'h0bad_f00d, 1'b0, '0, '0);
        checkOutput("resume_a_ready", 32'(a_ready), 32'd1);
        stepCycle();
        checkOutput("resume_wr_enable", 32'(wr_enable), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
